// File: rtl/axi_lite_cmd_master.sv
// AXI4-Lite initiator: serialises a valid/ready command stream into single AXI-Lite
// read/write transactions, one response per command. Optional counters: AXI_LITE_CMD_MASTER_STATS_EN.
module axi_lite_cmd_master #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                      ACLK,
  input  logic                      ARESET,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic                      cmd_write,
  input  logic [ADDR_WIDTH-1:0]     cmd_addr,
  input  logic [DATA_WIDTH-1:0]     cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0]   cmd_wstrb,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic                      rsp_write,
  output logic [DATA_WIDTH-1:0]     rsp_rdata,
  output logic [1:0]                rsp_resp,
  output logic [ADDR_WIDTH-1:0]     AWADDR,
  output logic                      AWVALID,
  input  logic                      AWREADY,
  output logic [DATA_WIDTH-1:0]     WDATA,
  output logic [DATA_WIDTH/8-1:0]   WSTRB,
  output logic                      WVALID,
  input  logic                      WREADY,
  input  logic [1:0]                BRESP,
  input  logic                      BVALID,
  output logic                      BREADY,
  output logic [ADDR_WIDTH-1:0]     ARADDR,
  output logic                      ARVALID,
  input  logic                      ARREADY,
  input  logic [DATA_WIDTH-1:0]     RDATA,
  input  logic [1:0]                RRESP,
  input  logic                      RVALID,
  output logic                      RREADY
`ifdef AXI_LITE_CMD_MASTER_STATS_EN
 ,output logic [31:0]               stat_writes,
  output logic [31:0]               stat_reads,
  output logic [31:0]               stat_errors
`endif
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_WRITE_RESP,
    ST_READ_ADDR,
    ST_READ_DATA,
    ST_RESPOND
  } state_t;

  state_t r_state, w_state_next;

  logic [ADDR_WIDTH-1:0]   r_awaddr, r_araddr;
  logic [DATA_WIDTH-1:0]   r_wdata, r_rsp_rdata;
  logic [DATA_WIDTH/8-1:0] r_wstrb;
  logic                    r_awvalid, r_wvalid, r_bready, r_arvalid, r_rready;
  logic                    r_aw_done, r_w_done;
  logic                    r_rsp_valid, r_rsp_write;
  logic [1:0]              r_rsp_resp;

  logic w_cmd_fire, w_aw_fire, w_w_fire, w_b_fire, w_ar_fire, w_r_fire, w_rsp_fire;
  logic w_aw_done, w_w_done;

  assign cmd_ready  = (r_state == ST_IDLE) && !ARESET;
  assign w_cmd_fire = cmd_valid & cmd_ready;
  assign w_aw_fire  = r_awvalid & AWREADY;
  assign w_w_fire   = r_wvalid & WREADY;
  assign w_b_fire   = r_bready & BVALID;
  assign w_ar_fire  = r_arvalid & ARREADY;
  assign w_r_fire   = r_rready & RVALID;
  assign w_rsp_fire = r_rsp_valid & rsp_ready;
  // AW and W complete independently; either may finish first or both together
  assign w_aw_done  = r_aw_done | w_aw_fire;
  assign w_w_done   = r_w_done | w_w_fire;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:       if (w_cmd_fire) w_state_next = cmd_write ? ST_WRITE : ST_READ_ADDR;
      ST_WRITE:      if (w_aw_done && w_w_done) w_state_next = ST_WRITE_RESP;
      ST_WRITE_RESP: if (w_b_fire) w_state_next = ST_RESPOND;
      ST_READ_ADDR:  if (w_ar_fire) w_state_next = ST_READ_DATA;
      ST_READ_DATA:  if (w_r_fire) w_state_next = ST_RESPOND;
      ST_RESPOND:    if (w_rsp_fire) w_state_next = ST_IDLE;
      default:       w_state_next = ST_IDLE;
    endcase
  end

`ifdef AXI_LITE_CMD_MASTER_STATS_EN
  logic [31:0] r_stat_writes, r_stat_reads, r_stat_errors;
  assign stat_writes = r_stat_writes;
  assign stat_reads  = r_stat_reads;
  assign stat_errors = r_stat_errors;

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_stat_writes <= '0;
      r_stat_reads  <= '0;
      r_stat_errors <= '0;
    end else begin
      if (r_state == ST_WRITE_RESP && w_b_fire) begin
        r_stat_writes <= r_stat_writes + 32'd1;
        if (BRESP != 2'b00) r_stat_errors <= r_stat_errors + 32'd1;
      end
      if (r_state == ST_READ_DATA && w_r_fire) begin
        r_stat_reads <= r_stat_reads + 32'd1;
        if (RRESP != 2'b00) r_stat_errors <= r_stat_errors + 32'd1;
      end
    end
  end
`endif

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_state     <= ST_IDLE;
      r_awaddr    <= '0;
      r_araddr    <= '0;
      r_wdata     <= '0;
      r_wstrb     <= '0;
      r_awvalid   <= 1'b0;
      r_wvalid    <= 1'b0;
      r_bready    <= 1'b0;
      r_arvalid   <= 1'b0;
      r_rready    <= 1'b0;
      r_aw_done   <= 1'b0;
      r_w_done    <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_write <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_resp  <= '0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        ST_IDLE: begin
          if (w_cmd_fire) begin
            if (cmd_write) begin
              r_awaddr  <= cmd_addr;
              r_wdata   <= cmd_wdata;
              r_wstrb   <= cmd_wstrb;
              r_awvalid <= 1'b1;
              r_wvalid  <= 1'b1;
              r_aw_done <= 1'b0;
              r_w_done  <= 1'b0;
            end else begin
              r_araddr  <= cmd_addr;
              r_arvalid <= 1'b1;
            end
          end
        end
        ST_WRITE: begin
          if (w_aw_fire) begin
            r_awvalid <= 1'b0;
            r_aw_done <= 1'b1;
          end
          if (w_w_fire) begin
            r_wvalid <= 1'b0;
            r_w_done <= 1'b1;
          end
          if (w_aw_done && w_w_done) r_bready <= 1'b1;
        end
        ST_WRITE_RESP: begin
          if (w_b_fire) begin
            r_bready    <= 1'b0;
            r_rsp_resp  <= BRESP;
            r_rsp_rdata <= '0;
            r_rsp_write <= 1'b1;
            r_rsp_valid <= 1'b1;
          end
        end
        ST_READ_ADDR: begin
          if (w_ar_fire) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
          end
        end
        ST_READ_DATA: begin
          if (w_r_fire) begin
            r_rready    <= 1'b0;
            r_rsp_rdata <= RDATA;
            r_rsp_resp  <= RRESP;
            r_rsp_write <= 1'b0;
            r_rsp_valid <= 1'b1;
          end
        end
        ST_RESPOND: begin
          if (w_rsp_fire) r_rsp_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign AWADDR    = r_awaddr;
  assign AWVALID   = r_awvalid;
  assign WDATA     = r_wdata;
  assign WSTRB     = r_wstrb;
  assign WVALID    = r_wvalid;
  assign BREADY    = r_bready;
  assign ARADDR    = r_araddr;
  assign ARVALID   = r_arvalid;
  assign RREADY    = r_rready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_write = r_rsp_write;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_resp  = r_rsp_resp;

endmodule

// File: doc/axi_lite_cmd_master.md
Name: axi_lite_cmd_master

Overview:
- AXI4-Lite initiator that turns a simple valid/ready command stream into single AXI-Lite read or write transactions.
- Returns one response per command on a valid/ready response stream.
- Drives the register slaves of the output-queue and pipeline cores from a local controller (test sequencer, config FSM), with no MicroBlaze/PCIe bridge in the path.
- Strictly one outstanding transaction; commands are serialised.

Parameters:
DATA_WIDTH, 32, AXI-Lite data width (32 or 64)
ADDR_WIDTH, 32, AXI-Lite address width

Ports:
ACLK  in  1  clock; all logic on rising edge
ARESET  in  1  synchronous, active-high reset
cmd_valid  in  1  command present
cmd_ready  out  1  command accepted when cmd_valid&cmd_ready
cmd_write  in  1  1=write, 0=read
cmd_addr  in  ADDR_WIDTH  byte address
cmd_wdata  in  DATA_WIDTH  write data (ignored on reads)
cmd_wstrb  in  DATA_WIDTH/8  write strobes (ignored on reads)
rsp_valid  out  1  response present
rsp_ready  in  1  response consumed when rsp_valid&rsp_ready
rsp_write  out  1  echo of cmd_write
rsp_rdata  out  DATA_WIDTH  read data; 0 for writes
rsp_resp  out  2  BRESP or RRESP from slave
AWADDR/AWVALID out, AWREADY in  AXI-Lite write address channel
WDATA/WSTRB/WVALID out, WREADY in  AXI-Lite write data channel
BRESP in 2, BVALID in, BREADY out  AXI-Lite write response channel
ARADDR/ARVALID out, ARREADY in  AXI-Lite read address channel
RDATA in DATA_WIDTH, RRESP in 2, RVALID in, RREADY out  AXI-Lite read data channel

Behaviour:
- States: IDLE, WRITE (AW+W in flight), WRITE_RESP, READ_ADDR, READ_DATA, RESPOND.
- Reset (ARESET=1 at an edge): state=IDLE. AWVALID, WVALID, ARVALID, BREADY, RREADY and rsp_valid all 0. AWADDR, WDATA, WSTRB, ARADDR, rsp_rdata, rsp_resp and rsp_write all 0.
- Reset mid-transaction abandons it with no response; all valids are low on the cycle after the reset edge.
- cmd_ready = (state==IDLE) && !ARESET. Combinational, no dependence on cmd_valid.
- IDLE, write accepted at edge N:
  - AWADDR, WDATA and WSTRB are registered from the command.
  - AWVALID=WVALID=1 from cycle N+1; go to WRITE.
- IDLE, read accepted at edge N: ARADDR registered, ARVALID=1 from N+1; go to READ_ADDR.
- WRITE:
  - AWVALID drops the edge after AWVALID&AWREADY; WVALID drops the edge after WVALID&WREADY.
  - Handshakes may occur in either order or on the same cycle; a per-channel done flag tracks each.
  - AW-before-W slaves (AW accepted, WREADY asserted only later) must complete.
  - Once both are done: go to WRITE_RESP, BREADY=1.
- WRITE_RESP: on BVALID&BREADY, capture BRESP into rsp_resp, rsp_rdata=0, rsp_write=1; BREADY=0; go to RESPOND.
- READ_ADDR: on ARVALID&ARREADY, ARVALID=0, RREADY=1; go to READ_DATA.
- READ_DATA: on RVALID&RREADY, capture RDATA/RRESP, rsp_write=0; RREADY=0; go to RESPOND.
- RESPOND:
  - rsp_valid=1, outputs held stable until rsp_ready.
  - On handshake: rsp_valid=0 next cycle, go to IDLE. The next command is acceptable the cycle after.
- Address, data and strobe outputs hold stable while their VALID is high, per AXI rules. VALID is never deasserted before its handshake.
- SLVERR (2'b10) and DECERR (2'b11) are passed through unmodified. The block never retries.
- Minimum latency with zero-wait slave and rsp_ready=1:
  - Write: cmd handshake edge N -> AW/W handshake edge N+1 -> B handshake edge N+2 -> rsp handshake edge N+3.
  - Read: the same cycle counts.
- The block has no timeout; a hung slave stalls it until reset.

Optional Feature:
- Macro AXI_LITE_CMD_MASTER_STATS_EN.
- When defined, three extra output ports are added, each 32 bits: stat_writes, stat_reads, stat_errors.
  - stat_writes and stat_reads increment on each completed B or R handshake respectively.
  - stat_errors increments when the captured resp != 2'b00.
  - Counters are cleared by ARESET and wrap modulo 2^32.
- When undefined, the ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- Zero-wait slave, write addr 0x20, data 0xDEADBEEF, wstrb 0xF: AWADDR=0x20 and WDATA=0xDEADBEEF at N+1; rsp_valid at N+3 with rsp_write=1, rsp_resp=00.
- AW-before-W slave (AWREADY at N+1, WREADY 3 cycles later): WVALID held high with stable WDATA until the handshake; exactly one response, resp=00.
- Read addr 0x10, slave returns RDATA=0x0000_0007 after 4 wait cycles: rsp_rdata=0x7, rsp_resp=00, ARVALID low after ARREADY.
- Read unmapped addr 0xFC, slave RRESP=10: rsp_resp=10 passed through; with STATS_EN, stat_errors=1 and stat_reads=1.
- rsp_ready held low 5 cycles with back-to-back cmd_valid: rsp outputs stable, cmd_ready=0 throughout; second command accepted only after the rsp handshake.
- ARESET asserted one cycle after AWVALID rises: all valids 0 next cycle, cmd_ready=1 after reset deasserts, no rsp_valid.
